// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
// Host request/response handshake plus the SPI serial pins of spi_master_ctrl.
// The master modport is the controller's view; the slave modport is the view
// of whatever sits around it (host and memory-block wrapper together).
interface spi_master_ctrl_if;
   // Host request side
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;

   // Host response side
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   // Serial port toward the memory-block wrapper
   logic       MOSI;
   logic       SS_n;
   logic       MISO;

   modport master (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  MISO,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output MOSI,
      output SS_n
   );

   modport slave (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      output MISO,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  MOSI,
      input  SS_n
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// Host-side SPI master for the memory-block wrapper. A host write is sent as
// a write-address frame and a write-data frame; a host read as a read-address
// frame and a read-data frame whose returned byte is shifted in from MISO.
// Every frame is {sel, cmd[1:0], payload[7:0]} MSB first with SS_n low,
// followed by GAP cycles with SS_n high.
//
// Optional feature: define ADDR_CACHE_EN to remember the last write address
// and the last read address; a request whose address matches the cached
// address of its own kind skips the address frame and its gap.
module spi_master_ctrl #(
   parameter int RD_WAIT = 1,  // idle cycles between read-data header and capture (0..7)
   parameter int GAP     = 1   // SS_n-high cycles after every frame (1..7)
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_master_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRAME,
      S_WAIT,
      S_CAPTURE,
      S_GAP
   } state_t;

   // Which of the four frame kinds is in flight (or just finished, in GAP).
   typedef enum logic [1:0] {
      PH_WR_ADDR,
      PH_WR_DATA,
      PH_RD_ADDR,
      PH_RD_DATA
   } phase_t;

   // Terminal values of the shared cycle counter in each state.
   localparam logic [3:0] LP_FRAME_LAST = 4'd10;           // 11-bit frame
   localparam logic [3:0] LP_HDR_LAST   = 4'd2;            // 3-bit read-data header
   localparam logic [3:0] LP_WAIT_LAST  = 4'(RD_WAIT - 1);
   localparam logic [3:0] LP_CAP_LAST   = 4'd7;            // 8 capture cycles
   localparam logic [3:0] LP_GAP_LAST   = 4'(GAP - 1);

   // Full 11-bit frame image for a given frame kind.
   function automatic logic [10:0] frame_bits(input phase_t     ph,
                                              input logic [7:0] addr,
                                              input logic [7:0] wdata);
      case (ph)
         PH_WR_ADDR: return {3'b100, addr};
         PH_WR_DATA: return {3'b101, wdata};
         PH_RD_ADDR: return {3'b010, addr};
         default:    return {3'b011, 8'h00};
      endcase
   endfunction

   // Control state
   state_t      r_state;
   phase_t      r_phase;
   logic [3:0]  r_cnt;

   // Latched request and serial datapath
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;
   logic [9:0]  r_shift;      // frame bits still to be sent after the current one
   logic [6:0]  r_rx;         // MISO bits captured so far

   // Registered outputs
   logic        r_mosi;
   logic        r_ss_n;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_rdata;

   // Decode helpers
   logic        w_wr_hit;
   logic        w_rd_hit;
   phase_t      w_acc_phase;
   logic [10:0] w_acc_frame;
   phase_t      w_next_phase;
   logic        w_has_next;
   logic [10:0] w_next_frame;
   logic        w_frame_last;

`ifdef ADDR_CACHE_EN
   logic [7:0]  r_wr_addr_c;
   logic        r_wr_c_vld;
   logic [7:0]  r_rd_addr_c;
   logic        r_rd_c_vld;

   assign w_wr_hit = r_wr_c_vld && (bus.req_addr == r_wr_addr_c);
   assign w_rd_hit = r_rd_c_vld && (bus.req_addr == r_rd_addr_c);
`else
   assign w_wr_hit = 1'b0;
   assign w_rd_hit = 1'b0;
`endif

   // First frame kind for the request being offered on the host port.
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_acc_phase = PH_WR_ADDR;
      if (bus.req_write) begin
         w_acc_phase = w_wr_hit ? PH_WR_DATA : PH_WR_ADDR;
      end else begin
         w_acc_phase = w_rd_hit ? PH_RD_DATA : PH_RD_ADDR;
      end
   end

   // Second frame of the transaction, if the finished frame was an address frame.
   always_comb begin
      w_next_phase = PH_RD_DATA;
      w_has_next   = 1'b0;
      case (r_phase)
         PH_WR_ADDR: begin
            w_next_phase = PH_WR_DATA;
            w_has_next   = 1'b1;
         end
         PH_RD_ADDR: begin
            w_next_phase = PH_RD_DATA;
            w_has_next   = 1'b1;
         end
         default: begin
            w_next_phase = PH_RD_DATA;
            w_has_next   = 1'b0;
         end
      endcase
   end

   assign w_acc_frame  = frame_bits(w_acc_phase, bus.req_addr, bus.req_wdata);
   assign w_next_frame = frame_bits(w_next_phase, r_addr, r_wdata);

   // The read-data frame only sends its 3-bit header before waiting/capturing.
   assign w_frame_last = (r_phase == PH_RD_DATA) ? (r_cnt == LP_HDR_LAST)
                                                 : (r_cnt == LP_FRAME_LAST);

   // Transaction sequencer: drives all serial and handshake outputs from registers.
   // NOTE: rst_n is sampled on the clock edge here, so reset is a synchronous
   // term of the same block rather than part of the sensitivity list.
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phase     <= PH_WR_ADDR;
         r_cnt       <= 4'd0;
         r_addr      <= 8'h00;
         r_wdata     <= 8'h00;
         r_shift     <= 10'd0;
         r_rx        <= 7'd0;
         r_mosi      <= 1'b0;
         r_ss_n      <= 1'b1;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'h00;
`ifdef ADDR_CACHE_EN
         r_wr_addr_c <= 8'h00;
         r_wr_c_vld  <= 1'b0;
         r_rd_addr_c <= 8'h00;
         r_rd_c_vld  <= 1'b0;
`endif
      end else begin
         // Response is a single-cycle pulse unless re-armed below.
         r_rsp_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_addr      <= bus.req_addr;
                  r_wdata     <= bus.req_wdata;
                  r_phase     <= w_acc_phase;
                  r_mosi      <= w_acc_frame[10];
                  r_shift     <= w_acc_frame[9:0];
                  r_ss_n      <= 1'b0;
                  r_req_ready <= 1'b0;
                  r_cnt       <= 4'd0;
                  r_state     <= S_FRAME;
               end
            end

            S_FRAME: begin
               if (w_frame_last) begin
                  r_cnt  <= 4'd0;
                  r_mosi <= 1'b0;
                  if (r_phase == PH_RD_DATA) begin
                     // SS_n stays low through the wait and capture window.
                     if (RD_WAIT == 0) begin
                        r_state <= S_CAPTURE;
                     end else begin
                        r_state <= S_WAIT;
                     end
                  end else begin
                     r_ss_n  <= 1'b1;
                     r_state <= S_GAP;
`ifdef ADDR_CACHE_EN
                     // Cache entries only become valid once the slave has
                     // actually seen the complete address frame.
                     if (r_phase == PH_WR_ADDR) begin
                        r_wr_addr_c <= r_addr;
                        r_wr_c_vld  <= 1'b1;
                     end
                     if (r_phase == PH_RD_ADDR) begin
                        r_rd_addr_c <= r_addr;
                        r_rd_c_vld  <= 1'b1;
                     end
`endif
                  end
               end else begin
                  r_cnt   <= r_cnt + 4'd1;
                  r_mosi  <= r_shift[9];
                  r_shift <= {r_shift[8:0], 1'b0};
               end
            end

            S_WAIT: begin
               if (r_cnt == LP_WAIT_LAST) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_CAPTURE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_CAPTURE: begin
               // MISO is sampled at the edge that ends each capture cycle.
               r_rx <= {r_rx[5:0], bus.MISO};
               if (r_cnt == LP_CAP_LAST) begin
                  r_rsp_rdata <= {r_rx, bus.MISO};
                  r_rsp_valid <= 1'b1;
                  r_ss_n      <= 1'b1;
                  r_cnt       <= 4'd0;
                  r_state     <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_GAP: begin
               if (r_cnt == LP_GAP_LAST) begin
                  r_cnt <= 4'd0;
                  if (w_has_next) begin
                     r_phase <= w_next_phase;
                     r_mosi  <= w_next_frame[10];
                     r_shift <= w_next_frame[9:0];
                     r_ss_n  <= 1'b0;
                     r_state <= S_FRAME;
                  end else begin
                     r_req_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            default: begin
               r_mosi      <= 1'b0;
               r_ss_n      <= 1'b1;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.MOSI      = r_mosi;
   assign bus.SS_n      = r_ss_n;
   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side SPI master that drives the memory-block wrapper's MOSI/SS_n/MISO serial port from a parallel request interface. Each host write becomes a write-address frame followed by a write-data frame. Each host read becomes a read-address frame followed by a read-data frame, and the returned byte is captured from MISO. It sits directly upstream of the memory-block wrapper and is the only driver of its serial pins.

## Interface
Parameters:
- `RD_WAIT`, default 1: idle cycles between the last read-data header bit and the first MISO capture cycle (range 0–7).
- `GAP`, default 1: SS_n-high cycles after every frame (range 1–7).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  1: host request present.
- `req_ready`  out  1: block idle; a request is accepted on a rising edge where `req_valid && req_ready`.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  8: memory address.
- `req_wdata`  in  8: write data; ignored for reads.
- `rsp_valid`  out  1: one-cycle pulse; `rsp_rdata` is valid.
- `rsp_rdata`  out  8: captured read byte; holds its value until the next capture.
- `MOSI`  out  1: serial data to the slave, MSB first.
- `SS_n`  out  1: slave select, active low.
- `MISO`  in  1: serial data from the slave.

## Operation
- States: IDLE, FRAME, WAIT, CAPTURE, GAP.
- Transitions:
  - IDLE goes to FRAME when a request is accepted.
  - FRAME goes to GAP after its last bit, or to WAIT/CAPTURE for a read-data frame.
  - WAIT goes to CAPTURE.
  - CAPTURE goes to GAP.
  - GAP goes to FRAME (second frame of the transaction) or to IDLE.
- On acceptance, the request fields are latched. Inputs are don't-care until `req_ready` returns high.
- Frame bit sequence is `{sel, cmd[1], cmd[0], payload[7:0]}`, one bit per cycle, with SS_n low for the whole frame.
  - Write address: sel=1, cmd=00, payload = addr.
  - Write data: sel=1, cmd=01, payload = wdata.
  - Read address: sel=0, cmd=10, payload = addr.
  - Read data: sel=0, cmd=11, no payload. Then `RD_WAIT` cycles with MOSI=0, then 8 CAPTURE cycles with MOSI=0.
- CAPTURE samples MISO at the rising edge ending each capture cycle and shifts it in MSB first.
- Address and data frames are 11 cycles long. The read-data frame is 3 + RD_WAIT + 8 cycles long.
- After every frame, SS_n is high for `GAP` cycles and MOSI=0.
- `rsp_valid` pulses in the first GAP cycle after a read-data frame. `rsp_rdata` updates in the same cycle.

## Timing
- Reset values: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0x00, state IDLE, cache flags cleared.
- Reset asserted mid-transaction aborts on the next edge:
  - SS_n=1 and MOSI=0 in the following cycle.
  - No rsp_valid is issued.
  - The slave sees a truncated frame.
- Cycle numbering: the acceptance edge is E0; cycle n is the cycle after edge E(n-1).
- Default write (GAP=1):
  - Cycles 1–11: address frame.
  - Cycle 12: gap.
  - Cycles 13–23: data frame.
  - Cycle 24: gap.
  - `req_ready`=1 from cycle 25.
- Default read (RD_WAIT=1, GAP=1):
  - Cycles 1–11: address frame.
  - Cycle 12: gap.
  - Cycles 13–24: read-data frame.
  - Cycle 25: gap, with `rsp_valid`=1.
  - `req_ready`=1 from cycle 26.
- `req_ready` is 0 from cycle 1 until return to IDLE. Back-to-back requests therefore have at least one IDLE cycle between them.
- `req_valid` high while `req_ready`=0 is ignored and not queued.

## Configuration
- `ADDR_CACHE_EN` defined:
  - The block keeps a last-write-address register and a last-read-address register, each with a valid flag. Both flags are cleared by reset.
  - If the latched address equals the valid cached address of the same kind, the address frame and its gap are skipped.
  - A cache hit shortens a default write to cycles 1–11 data frame, cycle 12 gap, idle at cycle 13.
  - The cache register and its valid flag update when the address frame completes.
- `ADDR_CACHE_EN` undefined: every transaction sends both frames; no cache registers exist.

## Test plan
- Reset for 5 cycles, then idle -> SS_n=1, MOSI=0, req_ready=1, rsp_valid=0 throughout.
- Write addr=100 (0x64), wdata=11 (0x0B) -> MOSI sequence `1,0,0,0,1,1,0,0,1,0,0`, gap, then `1,0,1,0,0,0,0,1,0,1,1`; req_ready returns at cycle 25.
- Write addresses 100..199 with data 11,22,…,253 wrapping to 11, then read the same addresses against the wrapper model -> every `rsp_rdata` matches; exactly one rsp_valid per read, at cycle 25.
- Read while the slave model drives MISO=0xA5 in the capture window -> rsp_rdata=0xA5; header `0,1,0,0x64 bits`, then `0,1,1`.
- Assert rst_n=0 at cycle 6 of a write -> SS_n=1 next cycle; no second frame; a subsequent request runs with normal timing.
- With `ADDR_CACHE_EN`, two writes to addr 42 -> the second shows only the data frame and req_ready returns at cycle 13; a read of addr 42 still sends its read-address frame.
